// File: rtl/process_scheduler.sv
// Round-robin process scheduler: process table, admission, preemption and dispatch FSM.
// Optional macro SCHED_IO_BLOCK_EN enables BLOCKED state for I/O waits and io_done wakeups.
module process_scheduler #(
   parameter int NPROC = 8,
   parameter int PIDW  = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            create_valid,
   input  logic [31:0]     create_pc,
   output logic            create_ready,
   input  logic            quantum_expired,
   input  logic            io_request,
   input  logic            proc_exit,
   input  logic [31:0]     saved_pc,
   input  logic            io_done_valid,
   input  logic [PIDW-1:0] io_done_pid,
   output logic            dispatch_valid,
   output logic [31:0]     dispatch_pc,
   output logic [PIDW-1:0] current_pid,
   output logic            cpu_idle
);

   typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_RUNNING, SLOT_BLOCKED} slot_state_t;
   typedef enum logic [2:0] {IDLE, RUN, SAVE, SCAN, DISPATCH} fsm_state_t;

`ifdef SCHED_IO_BLOCK_EN
   localparam slot_state_t IO_PARK = SLOT_BLOCKED;
`else
   localparam slot_state_t IO_PARK = SLOT_READY;
   logic unused_io_done;
   assign unused_io_done = io_done_valid | (|io_done_pid);
`endif

   slot_state_t     slot_state [NPROC];
   logic [31:0]     slot_pc    [NPROC];
   fsm_state_t      state;
   logic [PIDW-1:0] scan_idx;
   logic [PIDW-1:0] scan_cnt;
   logic [PIDW-1:0] sel_idx;

   logic            any_free;
   logic            any_ready;
   logic [PIDW-1:0] free_idx;
   logic            admit;

   // Descending walk so the lowest-index FREE slot is the one left in free_idx.
   always_comb begin
      any_free  = '0;
      any_ready = '0;
      free_idx  = '0;
      for (int unsigned i = NPROC; i > 0; i--) begin
         if (slot_state[i-1] == SLOT_FREE) begin
            any_free = '1;
            free_idx = PIDW'(i-1);
         end
         if (slot_state[i-1] == SLOT_READY) any_ready = '1;
      end
   end

   assign create_ready = any_free;
   assign admit        = create_valid & any_free;

   // Admission, io_done, and FSM writes always touch slots in distinct states,
   // so they never collide on the same table entry in one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NPROC; i++) begin
            slot_state[i] <= SLOT_FREE;
            slot_pc[i]    <= '0;
         end
         state          <= IDLE;
         current_pid    <= PIDW'(NPROC-1);
         scan_idx       <= '0;
         scan_cnt       <= '0;
         sel_idx        <= '0;
         dispatch_valid <= '0;
         dispatch_pc    <= '0;
         cpu_idle       <= '1;
      end else begin
         dispatch_valid <= '0;
`ifdef SCHED_IO_BLOCK_EN
         if (io_done_valid && slot_state[io_done_pid] == SLOT_BLOCKED)
            slot_state[io_done_pid] <= SLOT_READY;
`endif
         if (admit) begin
            slot_state[free_idx] <= SLOT_READY;
            slot_pc[free_idx]    <= create_pc;
         end
         case (state)
            IDLE: begin
               if (any_ready) begin
                  state    <= SCAN;
                  scan_idx <= current_pid + PIDW'(1);
                  scan_cnt <= '0;
               end
            end
            RUN: begin
               if (proc_exit) begin
                  slot_state[current_pid] <= SLOT_FREE;
                  state    <= SCAN;
                  scan_idx <= current_pid + PIDW'(1);
                  scan_cnt <= '0;
                  cpu_idle <= '1;
               end else if (io_request) begin
                  slot_pc[current_pid]    <= saved_pc;
                  slot_state[current_pid] <= IO_PARK;
                  state    <= SAVE;
                  cpu_idle <= '1;
               end else if (quantum_expired) begin
                  slot_pc[current_pid]    <= saved_pc;
                  slot_state[current_pid] <= SLOT_READY;
                  state    <= SAVE;
                  cpu_idle <= '1;
               end
            end
            SAVE: begin
               state    <= SCAN;
               scan_idx <= current_pid + PIDW'(1);
               scan_cnt <= '0;
            end
            SCAN: begin
               if (slot_state[scan_idx] == SLOT_READY) begin
                  sel_idx  <= scan_idx;
                  state    <= DISPATCH;
                  cpu_idle <= '0;
               end else if (scan_cnt == PIDW'(NPROC-1)) begin
                  state <= IDLE;
               end else begin
                  scan_idx <= scan_idx + PIDW'(1);
                  scan_cnt <= scan_cnt + PIDW'(1);
               end
            end
            DISPATCH: begin
               slot_state[sel_idx] <= SLOT_RUNNING;
               current_pid    <= sel_idx;
               dispatch_pc    <= slot_pc[sel_idx];
               dispatch_valid <= '1;
               state          <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: expected dispatches are queued at stimulus
// time and matched by a monitor whenever dispatch_valid pulses.
module tb_process_scheduler;
   localparam int NPROC = 8;
   localparam int PIDW  = 3;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            create_valid = 1'b0;
   logic [31:0]     create_pc = '0;
   logic            create_ready;
   logic            quantum_expired = 1'b0;
   logic            io_request = 1'b0;
   logic            proc_exit = 1'b0;
   logic [31:0]     saved_pc = '0;
   logic            io_done_valid = 1'b0;
   logic [PIDW-1:0] io_done_pid = '0;
   logic            dispatch_valid;
   logic [31:0]     dispatch_pc;
   logic [PIDW-1:0] current_pid;
   logic            cpu_idle;

   int passed = 0;
   int total  = 0;
   logic [PIDW+31:0] exp_q [$];

   always #5 clock = ~clock;

   process_scheduler #(.NPROC(NPROC), .PIDW(PIDW)) dut (
      .clock(clock), .reset(reset),
      .create_valid(create_valid), .create_pc(create_pc), .create_ready(create_ready),
      .quantum_expired(quantum_expired), .io_request(io_request), .proc_exit(proc_exit),
      .saved_pc(saved_pc), .io_done_valid(io_done_valid), .io_done_pid(io_done_pid),
      .dispatch_valid(dispatch_valid), .dispatch_pc(dispatch_pc),
      .current_pid(current_pid), .cpu_idle(cpu_idle)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic create(input logic [31:0] pc);
      create_valid = 1'b1;
      create_pc    = pc;
      tick();
      create_valid = 1'b0;
   endtask

   // Pulse RUN events for one cycle and expect a dispatch exactly lat edges later.
   task automatic run_event(input bit q, input bit io, input bit ex, input logic [31:0] spc,
                            input int lat, input logic [PIDW-1:0] epid, input logic [31:0] epc);
      exp_q.push_back({epid, epc});
      quantum_expired = q;
      io_request      = io;
      proc_exit       = ex;
      saved_pc        = spc;
      tick();
      quantum_expired = 1'b0;
      io_request      = 1'b0;
      proc_exit       = 1'b0;
      repeat (lat-1) tick();
      check("early_dispatch", 32'(dispatch_valid), 32'd0);
      tick();
      check("dispatch_valid", 32'(dispatch_valid), 32'd1);
      check("current_pid", 32'(current_pid), 32'(epid));
   endtask

   // Scoreboard side: every dispatch pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!reset && dispatch_valid) begin
         total++;
         assert (exp_q.size() != 0) passed++;
         else $error("FAIL unexpected_dispatch: observed pid %0d pc %0h expected no dispatch",
                     current_pid, dispatch_pc);
         if (exp_q.size() != 0) begin
            logic [PIDW+31:0] e;
            e = exp_q.pop_front();
            check("sb_pid", 32'(current_pid), 32'(e[PIDW+31:32]));
            check("sb_pc", dispatch_pc, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check("rst_create_ready", 32'(create_ready), 32'd1);
      check("rst_cpu_idle", 32'(cpu_idle), 32'd1);
      check("rst_dispatch_valid", 32'(dispatch_valid), 32'd0);
      check("rst_dispatch_pc", dispatch_pc, 32'd0);
      check("rst_current_pid", 32'(current_pid), 32'(NPROC-1));

      // First admission from IDLE: dispatch three edges after the create edge.
      exp_q.push_back({3'd0, 32'h100});
      create(32'h100);
      repeat (2) tick();
      check("first_early", 32'(dispatch_valid), 32'd0);
      check("dispatch_cpu_idle", 32'(cpu_idle), 32'd0);
      tick();
      check("first_valid", 32'(dispatch_valid), 32'd1);
      check("first_pid", 32'(current_pid), 32'd0);
      check("first_pc", dispatch_pc, 32'h100);
      tick();
      check("valid_one_cycle", 32'(dispatch_valid), 32'd0);

      // Round robin with preemption; the last hop skips FREE slots 3..7 (k=5).
      create(32'h200);
      create(32'h300);
      run_event(1, 0, 0, 32'h105, 3, 3'd1, 32'h200);
      run_event(1, 0, 0, 32'h205, 3, 3'd2, 32'h300);
      run_event(1, 0, 0, 32'h305, 8, 3'd0, 32'h105);

      // Exit beats quantum: slot 0 is freed and 0xDEAD is never stored.
      run_event(1, 0, 1, 32'hDEAD, 2, 3'd1, 32'h205);
      check("exit_create_ready", 32'(create_ready), 32'd1);
      run_event(0, 0, 1, 32'h0, 2, 3'd2, 32'h305);
      create(32'h400);
      run_event(1, 0, 0, 32'h309, 8, 3'd0, 32'h400);
      run_event(0, 0, 1, 32'h0, 3, 3'd2, 32'h309);

`ifdef SCHED_IO_BLOCK_EN
      io_request = 1'b1;
      saved_pc   = 32'h777;
      tick();
      io_request = 1'b0;
      repeat (11) tick();
      check("io_block_idle", 32'(cpu_idle), 32'd1);
      check("io_block_no_dispatch", 32'(dispatch_valid), 32'd0);
      io_done_valid = 1'b1;
      io_done_pid   = 3'd5;
      tick();
      io_done_valid = 1'b0;
      repeat (4) tick();
      check("io_done_free_ignored", 32'(cpu_idle), 32'd1);
      exp_q.push_back({3'd2, 32'h777});
      io_done_valid = 1'b1;
      io_done_pid   = 3'd2;
      tick();
      io_done_valid = 1'b0;
      repeat (9) tick();
      check("io_wake_early", 32'(dispatch_valid), 32'd0);
      tick();
      check("io_wake_valid", 32'(dispatch_valid), 32'd1);
      check("io_wake_pid", 32'(current_pid), 32'd2);
`else
      run_event(0, 1, 0, 32'h777, 10, 3'd2, 32'h777);
`endif

      // Fill the table; a ninth create must not overwrite slot 0.
      for (int i = 0; i < 7; i++) create(32'h1000 + 32'(i) * 32'h10);
      check("full_create_ready", 32'(create_ready), 32'd0);
      create(32'hBAD);
      check("ninth_create_ready", 32'(create_ready), 32'd0);
      run_event(1, 0, 0, 32'h77A, 3, 3'd3, 32'h1020);
      run_event(1, 0, 0, 32'h1021, 3, 3'd4, 32'h1030);
      run_event(1, 0, 0, 32'h1031, 3, 3'd5, 32'h1040);
      run_event(1, 0, 0, 32'h1041, 3, 3'd6, 32'h1050);
      run_event(1, 0, 0, 32'h1051, 3, 3'd7, 32'h1060);
      run_event(1, 0, 0, 32'h1061, 3, 3'd0, 32'h1000);

      // Reset while in SCAN: no dispatch may follow and the table must be empty.
      quantum_expired = 1'b1;
      saved_pc        = 32'h1001;
      tick();
      quantum_expired = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("scan_rst_valid", 32'(dispatch_valid), 32'd0);
      check("scan_rst_pid", 32'(current_pid), 32'(NPROC-1));
      check("scan_rst_pc", dispatch_pc, 32'd0);
      check("scan_rst_create_ready", 32'(create_ready), 32'd1);
      repeat (6) tick();
      check("scan_rst_idle", 32'(cpu_idle), 32'd1);
      check("scan_rst_no_dispatch", 32'(dispatch_valid), 32'd0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/process_scheduler.md
PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 Parameter NPROC, default 8, SHALL set the number of process-table slots (power of two, 2..16).
REQ-002 Parameter PIDW, default 3, SHALL set the PID width, equal to log2(NPROC).
REQ-003 Port clock, input, 1, SHALL be the rising-edge clock for all state.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port create_valid, input, 1, SHALL request admission of a new process.
REQ-006 Port create_pc, input, 32, SHALL give the start PC of the new process.
REQ-007 Port create_ready, output, 1, SHALL be high when a FREE slot exists.
REQ-008 Port quantum_expired, input, 1, SHALL be a one-cycle pulse from the quantum counter requesting preemption.
REQ-009 Port io_request, input, 1, SHALL be a one-cycle pulse indicating the running process issued an I/O instruction.
REQ-010 Port proc_exit, input, 1, SHALL be a one-cycle pulse indicating the running process finished.
REQ-011 Port saved_pc, input, 32, SHALL give the resume PC of the running process; it is sampled with quantum_expired or io_request.
REQ-012 Port io_done_valid / io_done_pid, input, 1 / PIDW, SHALL report I/O completion for the given PID.
REQ-013 Port dispatch_valid, output, 1, SHALL pulse for one cycle when a process is dispatched.
REQ-014 Port dispatch_pc, output, 32, SHALL give the PC to load; it is valid with dispatch_valid.
REQ-015 Port current_pid, output, PIDW, SHALL give the PID of the running process.
REQ-016 Port cpu_idle, output, 1, SHALL be high when no process is RUNNING.

Function
REQ-017 Each slot SHALL hold a 32-bit PC and a state from {FREE, READY, RUNNING, BLOCKED}.
REQ-018 The FSM SHALL have the states IDLE, RUN, SAVE, SCAN and DISPATCH.
REQ-019 Admission: create_valid with create_ready SHALL, on that edge, write the lowest-index FREE slot to READY with PC=create_pc; admission SHALL be accepted in any FSM state.
REQ-020 IDLE: when any slot is READY, the FSM SHALL go to SCAN; otherwise it SHALL stay in IDLE with cpu_idle=1.
REQ-021 RUN: proc_exit SHALL free the current slot and go to SCAN.
REQ-022 RUN: quantum_expired SHALL store saved_pc, mark the current slot READY and go to SAVE.
REQ-023 RUN: io_request SHALL store saved_pc, mark the current slot BLOCKED and go to SAVE.
REQ-024 Priority for simultaneous events in RUN SHALL be proc_exit > io_request > quantum_expired.
REQ-025 SAVE SHALL last exactly one cycle and then go to SCAN.
REQ-026 SCAN SHALL examine one slot per cycle, round-robin from current_pid+1 modulo NPROC, including the previous process last.
REQ-027 SCAN SHALL go to DISPATCH on the first READY slot; after NPROC misses it SHALL go to IDLE.
REQ-028 DISPATCH SHALL mark the selected slot RUNNING, update current_pid, drive dispatch_pc, pulse dispatch_valid for exactly one cycle and go to RUN.
REQ-029 Latency from a preemption pulse to dispatch_valid SHALL be 3+k cycles, where k is the number of slots skipped in the scan.
REQ-030 io_done_valid for a BLOCKED slot SHALL set that slot READY; for a slot in any other state it SHALL be ignored.
REQ-031 If io_done and a SCAN visit hit the same slot in the same cycle, the slot SHALL be treated as not READY for that visit.
REQ-032 quantum_expired, io_request and proc_exit outside RUN SHALL be ignored.
REQ-033 cpu_idle SHALL be 1 in IDLE, SCAN and SAVE, and 0 in RUN and DISPATCH.
REQ-034 With all slots non-FREE, create_ready SHALL be 0 and create_valid SHALL have no effect.

Reset
REQ-035 Reset SHALL set all slots to FREE, all slot PCs to 0 and the FSM to IDLE.
REQ-036 Reset SHALL set current_pid=NPROC-1 so that the first scan starts at slot 0.
REQ-037 Reset SHALL set dispatch_valid=0, dispatch_pc=0, cpu_idle=1 and create_ready=1.
REQ-038 Reset asserted mid-SCAN or mid-DISPATCH SHALL abort the operation with no dispatch_valid pulse.
REQ-039 Reset SHALL take priority over all other inputs on the same edge.

Configuration
REQ-040 With macro SCHED_IO_BLOCK_EN defined, io_request SHALL block the process as in REQ-023, and io_done SHALL behave as in REQ-030.
REQ-041 Without SCHED_IO_BLOCK_EN, io_request SHALL be handled identically to quantum_expired (slot READY), io_done_valid SHALL be ignored, and no slot SHALL ever be BLOCKED.

Verification
REQ-042 Reset, then create 0x100 -> after 3 cycles dispatch_valid=1, dispatch_pc=0x100, current_pid=0.
REQ-043 Create 0x100, 0x200 and 0x300; quantum_expired with saved_pc=0x105 -> next dispatch is pid1 at 0x200; later pid2, then pid0 at 0x105.
REQ-044 With SCHED_IO_BLOCK_EN, one process receives io_request -> SCAN misses all slots, FSM goes to IDLE, cpu_idle=1; io_done_pid=0 -> re-dispatch at saved_pc.
REQ-045 proc_exit and quantum_expired in the same cycle -> slot FREE, saved_pc not stored, create_ready=1.
REQ-046 Fill all 8 slots -> create_ready=0 and a ninth create is ignored; reset asserted during SCAN -> no dispatch pulse and all slots FREE.
